// File: rtl/pool_stream.sv
// pool_stream: streaming PxP non-overlapping pooling (average or max) over a raster pixel stream.
// Latency: the pooled pixel is registered 1 clock after the accept of its window's last pixel.
// Backpressure: in_ready drops while a result is held by out_ready=0; no input is ever dropped.
// Ports: clk/rst (synchronous, active-high); start/mode frame control; in_valid/in_ready/in_pixel
//        input stream; out_valid/out_ready/out_pixel pooled stream; busy/frame_done frame status.
module pool_stream #(
  parameter int DW    = 16,
  parameter int P     = 2,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_pixel,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int LP = $clog2(P);
  localparam int AW = DW + 2 * LP;                 // headroom for a P*P sum
  localparam int NW = IMG_W / P;                   // windows per row band
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int JW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Elaboration-time parameter checks
  if (P < 2 || (P & (P - 1)) != 0) begin : g_chk_p
    $error("pool_stream: P must be a power of 2 and at least 2");
  end
  if (IMG_W < P || (IMG_W % P) != 0) begin : g_chk_w
    $error("pool_stream: IMG_W must be a non-zero multiple of P");
  end
  if (IMG_H < P || (IMG_H % P) != 0) begin : g_chk_h
    $error("pool_stream: IMG_H must be a non-zero multiple of P");
  end

  logic [1:0]          state;
  logic [RW-1:0]       row;
  logic [CW-1:0]       col;
  logic                mode_q;
  logic signed [AW-1:0] acc [NW];

  logic                accept;
  logic [JW-1:0]       j;
  logic [LP-1:0]       ri;
  logic [LP-1:0]       ci;
  logic                win_start;
  logic                win_close;
  logic                last_pix;
  logic signed [AW-1:0] x_ext;
  logic signed [AW-1:0] acc_cur;
  logic signed [AW-1:0] combined;
  logic signed [AW-1:0] avg_shift;
  logic signed [DW-1:0] pooled;

  // A new pixel may enter only when the output slot is free or is being emptied this cycle.
  assign in_ready   = (state == S_RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign frame_done = (state == S_DONE);

  assign j         = JW'(col >> LP);
  assign ri        = row[LP-1:0];
  assign ci        = col[LP-1:0];
  assign win_start = (ri == '0) && (ci == '0);
  assign win_close = (&ri) && (&ci);               // P-1 is all ones since P is a power of 2
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign x_ext     = {{(AW-DW){in_pixel[DW-1]}}, in_pixel};
  assign acc_cur   = acc[j];

  // Fold the current pixel into its window's partial result; the same value both updates the
  // accumulator and, on a window close, feeds the output register.
  always_comb begin
    combined = x_ext;
    if (!win_start) begin
      if (mode_q) combined = (x_ext > acc_cur) ? x_ext : acc_cur;
      else        combined = acc_cur + x_ext;
    end
    avg_shift = combined >>> (2 * LP);             // floor division by P*P
    pooled    = mode_q ? DW'(combined) : DW'(avg_shift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RUN;
            mode_q <= mode;
            row    <= '0;
            col    <= '0;
          end
        end
        S_RUN:   if (accept && last_pix) state <= S_DRAIN;
        S_DRAIN: if (out_valid && out_ready) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      // A load takes priority over the clear so back-to-back results stream without a bubble.
      if (accept && win_close) begin
        out_pixel <= pooled;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Partial results are always overwritten at a window start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) acc[j] <= combined;
  end

endmodule

// File: tb/tb_pool_stream.sv
`timescale 1ns/1ps
module tb_pool_stream;
  localparam int DW = 16;
  localparam int P  = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NP = W * H;
  localparam int NO = NP / (P * P);

  logic clk = 1'b0;
  logic rst, start, mode, in_valid, in_ready, out_valid, out_ready, busy, frame_done;
  logic signed [DW-1:0] in_pixel, out_pixel;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int obs_q[$];
  int model_out[$];
  int mon_idx = 0;
  int fd_cnt = 0;
  int fd_exp = 0;
  int hold_cnt = 0;
  int prev_pix = 0;
  bit hold_arm = 1'b0;
  bit bp_rand = 1'b0;
  bit lat_pending = 1'b0;
  bit prev_hold = 1'b0;

  always #5 clk = ~clk;

  pool_stream #(.DW(DW), .P(P), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic die(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting on the DUT", nm);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference: pool each PxP block of the frame directly, in the order windows complete.
  task automatic model_frame(input int pix[NP], input bit m);
    model_out.delete();
    for (int by = 0; by < H / P; by++) begin
      for (int bx = 0; bx < W / P; bx++) begin
        int s, mx, q, v;
        s  = 0;
        mx = pix[by * P * W + bx * P];
        for (int dy = 0; dy < P; dy++) begin
          for (int dx = 0; dx < P; dx++) begin
            v = pix[(by * P + dy) * W + bx * P + dx];
            s += v;
            if (v > mx) mx = v;
          end
        end
        if (m) q = mx;
        else begin
          q = s / (P * P);
          if ((s % (P * P)) != 0 && s < 0) q -= 1;
        end
        model_out.push_back(q);
      end
    end
  endtask

  // Downstream ready: optional random stalls, plus a one-shot 5-cycle stall on the first result.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else if (hold_arm && out_valid) begin
        out_ready = 1'b0;
        hold_cnt  = 4;
        hold_arm  = 1'b0;
      end else begin
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Compare process: every output handshake, hold stability, and 1-clock latency.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        lat_pending = 1'b0;
        prev_hold   = 1'b0;
      end else begin
        if (frame_done) fd_cnt++;
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_pixel", int'(out_pixel), prev_pix);
        end
        if (lat_pending) begin
          chk("latency_valid", out_valid, 1);
          if (exp_q.size() > 0) chk("latency_pixel", int'(out_pixel), exp_q[0]);
          lat_pending = 1'b0;
        end
        if (out_valid && !out_ready) chk("in_ready_blocked", in_ready, 0);
        if (out_valid && out_ready) begin
          obs_q.push_back(int'(out_pixel));
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %0d expected none", int'(out_pixel));
          end else begin
            chk("out_pixel", int'(out_pixel), exp_q.pop_front());
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_pix  = int'(out_pixel);
        if (in_valid && in_ready) begin
          if (((mon_idx / W) % P) == P - 1 && ((mon_idx % W) % P) == P - 1) lat_pending = 1'b1;
          mon_idx++;
        end
      end
    end
  end

  task automatic feed_pixel(input int v, input bit do_start, input bit m_val);
    int t;
    in_valid = 1'b1;
    in_pixel = DW'(v);
    if (do_start) begin
      start = 1'b1;
      mode  = m_val;
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 1000) die("in_ready_wait");
    end
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int pix[NP], input bit m, input bit gaps, input int glitch_at);
    int t;
    model_frame(pix, m);
    exp_q = model_out;
    obs_q.delete();
    mon_idx = 0;
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("busy_run", busy, 1);
    tick();
    for (int i = 0; i < NP; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      feed_pixel(pix[i], (i == glitch_at), !m);
    end
    in_valid = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (frame_done) break;
      t++;
      if (t > 1000) die("frame_done_wait");
    end
    chk("busy_at_done", busy, 0);
    chk("in_ready_at_done", in_ready, 0);
    fd_exp++;
    tick();
    @(negedge clk);
    chk("frame_done_one_cycle", frame_done, 0);
    tick();
    chk("leftover_expected", exp_q.size(), 0);
    chk("output_count", obs_q.size(), NO);
  endtask

  task automatic check_obs(input string nm, input int e[NO]);
    for (int k = 0; k < NO; k++) begin
      if (k < obs_q.size()) chk(nm, obs_q[k], e[k]);
    end
  endtask

  initial begin
    int seq[NP];
    int pix[NP];
    int e_avg[NO];
    int e_max[NO];
    logic signed [DW-1:0] r;

    e_avg = '{3, 5, 11, 13};
    e_max = '{6, 8, 14, 16};
    for (int i = 0; i < NP; i++) seq[i] = i + 1;

    rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; in_pixel = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_out_pixel", int'(out_pixel), 0);
    tick();
    rst = 1'b0;
    tick();

    // Pin the model with hand-computed values
    model_frame(seq, 1'b0);
    for (int k = 0; k < NO; k++) chk("model_avg", model_out[k], e_avg[k]);
    model_frame(seq, 1'b1);
    for (int k = 0; k < NO; k++) chk("model_max", model_out[k], e_max[k]);

    // Average and max over the 1..16 ramp
    run_frame(seq, 1'b0, 1'b0, -1);
    check_obs("ramp_avg", e_avg);
    run_frame(seq, 1'b1, 1'b0, -1);
    check_obs("ramp_max", e_max);

    // Negative floor in average mode and signed compare in max mode
    for (int i = 0; i < NP; i++) pix[i] = 0;
    pix[0] = -1; pix[1] = -2; pix[4] = -2; pix[5] = -2;
    model_frame(pix, 1'b0);
    chk("model_neg_avg", model_out[0], -2);
    run_frame(pix, 1'b0, 1'b0, -1);
    if (obs_q.size() > 0) chk("neg_avg_first", obs_q[0], -2);
    pix[0] = -5; pix[1] = -3; pix[4] = -9; pix[5] = -4;
    model_frame(pix, 1'b1);
    chk("model_neg_max", model_out[0], -3);
    run_frame(pix, 1'b1, 1'b0, -1);
    if (obs_q.size() > 0) chk("neg_max_first", obs_q[0], -3);

    // Five-cycle downstream stall on the first result
    hold_arm = 1'b1;
    run_frame(seq, 1'b0, 1'b0, -1);
    check_obs("backpressure_avg", e_avg);

    // start with flipped mode mid-frame must be ignored
    run_frame(seq, 1'b0, 1'b0, 6);
    check_obs("start_ignored", e_avg);

    // Abort after 6 accepted pixels
    model_frame(seq, 1'b0);
    exp_q = model_out;
    obs_q.delete();
    mon_idx = 0;
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) feed_pixel(seq[i], 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_frame_done", frame_done, 0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    mon_idx = 0;
    tick();
    run_frame(seq, 1'b0, 1'b0, -1);
    check_obs("after_abort", e_avg);

    // Randomized frames with input gaps and downstream stalls
    bp_rand = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NP; i++) begin
        r = DW'($urandom);
        pix[i] = int'(r);
      end
      run_frame(pix, 1'($urandom_range(0, 1)), 1'b1, -1);
    end
    bp_rand = 1'b0;
    repeat (3) tick();

    chk("frame_done_count", fd_cnt, fd_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
